// File: rtl/redun_mont_pkg.sv
// Shared types for the redundant Montgomery squaring datapath and its iteration sequencer.
package redun_mont_pkg;

  localparam int NUM_WRDS   = 8;
  localparam int WRD_BITS   = 17;
  localparam int SEQ_ITER_W = 64;

  // Carry-save style operand: each word keeps spare bits above the radix.
  typedef logic [NUM_WRDS-1:0][WRD_BITS-1:0] redun0_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE,
    ERR
  } seq_state_t;

endpackage

// File: rtl/redun_sq_seq_wdog.sv
// Datapath-result watchdog: loadable down-counter that flags a timeout on its last enabled cycle.
module redun_sq_seq_wdog #(
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_load,
  input  logic i_en,
  output logic o_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYC);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (i_clr) begin
      cnt_q <= '0;
    end else if (i_load) begin
      cnt_q <= LOAD_VAL;
    end else if (i_en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // cnt_q==1 marks the TIMEOUT_CYC-th enabled cycle after the load.
  assign o_timeout = i_en && !i_clr && !i_load && (cnt_q == CW'(1));

endmodule

// File: rtl/redun_sq_seq.sv
// Iteration sequencer feeding redun_mont one squaring at a time for VDF evaluation.
// Optional periodic checkpoint outputs are enabled by defining REDUN_SQ_SEQ_CHKPT_EN.
module redun_sq_seq
  import redun_mont_pkg::*;
#(
  parameter int ITER_W      = SEQ_ITER_W,
  parameter int TIMEOUT_CYC = 1023
`ifdef REDUN_SQ_SEQ_CHKPT_EN
  ,
  parameter int CHKPT_INTV  = 1024
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  redun0_t           i_sq_in,
  input  logic [ITER_W-1:0] i_iter,
  output logic              o_ready,
  output logic              o_busy,
  output redun0_t           o_sq_out,
  output logic              o_valid,
  output logic              o_err,
  output logic [ITER_W-1:0] o_iter_cnt,
  output redun0_t           o_mul_sq,
  output logic              o_mul_val,
  input  redun0_t           i_mul_o,
  input  logic              i_mul_val
`ifdef REDUN_SQ_SEQ_CHKPT_EN
  ,
  output logic              o_chkpt_val,
  output redun0_t           o_chkpt_sq
`endif
);

  seq_state_t        state_q, state_nxt;
  redun0_t           opnd_q;
  logic [ITER_W-1:0] target_q;
  logic [ITER_W-1:0] cnt_inc;
  logic              start_ok;
  logic              wait_hit;
  logic              timeout;

  assign cnt_inc  = o_iter_cnt + ITER_W'(1);
  assign start_ok = o_ready && i_start && !i_abort;
  assign wait_hit = (state_q == WAIT) && i_mul_val && !i_abort;
  assign o_mul_sq = opnd_q;

  redun_sq_seq_wdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdog (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (i_abort),
    .i_load    (state_q == ISSUE),
    .i_en      (state_q == WAIT),
    .o_timeout (timeout)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // A returning result beats a watchdog expiry in the same cycle; abort beats everything.
  always_comb begin
    state_nxt = state_q;
    o_ready   = 1'b0;
    o_busy    = 1'b0;
    o_mul_val = 1'b0;
    unique case (state_q)
      IDLE, ERR: begin
        o_ready = 1'b1;
        if (i_start) state_nxt = (i_iter == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        o_busy    = 1'b1;
        o_mul_val = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        o_busy = 1'b1;
        if (i_mul_val) state_nxt = (cnt_inc == target_q) ? DONE : ISSUE;
        else if (timeout) state_nxt = ERR;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (i_abort) state_nxt = IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      opnd_q     <= '0;
      target_q   <= '0;
      o_iter_cnt <= '0;
    end else if (start_ok) begin
      opnd_q     <= i_sq_in;
      target_q   <= i_iter;
      o_iter_cnt <= '0;
    end else if (wait_hit) begin
      opnd_q     <= i_mul_o;
      o_iter_cnt <= cnt_inc;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sq_out <= '0;
      o_valid  <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if ((state_q == DONE) && !i_abort) begin
        o_sq_out <= opnd_q;
        o_valid  <= 1'b1;
      end
      if (start_ok || ((state_q == ERR) && i_abort)) begin
        o_err <= 1'b0;
      end else if ((state_q == WAIT) && !i_mul_val && timeout && !i_abort) begin
        o_err <= 1'b1;
      end
    end
  end

`ifdef REDUN_SQ_SEQ_CHKPT_EN
  localparam int PW = (CHKPT_INTV > 1) ? $clog2(CHKPT_INTV) : 1;

  logic [PW-1:0] phase_q;

  // phase_q tracks completions modulo CHKPT_INTV without a wide divider.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase_q     <= '0;
      o_chkpt_val <= 1'b0;
      o_chkpt_sq  <= '0;
    end else begin
      o_chkpt_val <= 1'b0;
      if (start_ok) begin
        phase_q <= '0;
      end else if (wait_hit) begin
        if (phase_q == PW'(CHKPT_INTV - 1)) begin
          phase_q <= '0;
          if (cnt_inc != target_q) begin
            o_chkpt_val <= 1'b1;
            o_chkpt_sq  <= i_mul_o;
          end
        end else begin
          phase_q <= phase_q + PW'(1);
        end
      end
    end
  end
`endif

endmodule
